// File: rtl/ping_initiator.sv
// rtl/ping_initiator.sv - initiating-side ping-pong protocol engine driving the PPM encoder/decoder
module ping_initiator #(
    parameter int N_PKT   = 8,
    parameter int TIMEOUT = 1465,
    parameter int GAP     = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_PKT-1:0] data2send,
    input  logic [N_PKT-1:0] data_expected,
    output logic             start_ENC,
    input  logic             avail_ENC,
    output logic [N_PKT-1:0] data_ENC,
    input  logic [N_PKT-1:0] data_DEC,
    input  logic             avail_DEC,
    input  logic             error_DEC,
    output logic             read_DEC,
    output logic             expected_data_received,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] timeout_count,
    output logic [CNT_W-1:0] stray_count
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_DECODE   = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, SETTLE} state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [GAP_W-1:0] gap_cnt;
    logic             pkt;

    // The cycle after a read the decoder may still show avail_DEC, so it is ignored.
    assign pkt = avail_DEC && !read_DEC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            timer                  <= '0;
            gap_cnt                <= '0;
            start_ENC              <= 1'b0;
            data_ENC               <= '0;
            read_DEC               <= 1'b0;
            expected_data_received <= 1'b0;
            err_code               <= ERR_NONE;
            timeout_count          <= '0;
            stray_count            <= '0;
        end else begin
            start_ENC              <= 1'b0;
            read_DEC               <= 1'b0;
            expected_data_received <= 1'b0;

            if (state != WAIT_RX && pkt) begin
                read_DEC <= 1'b1;
                if (stray_count != '1)
                    stray_count <= stray_count + CNT_W'(1);
            end

            case (state)
                IDLE: state <= SEND;
                SEND: begin
                    if (avail_ENC) begin
                        start_ENC <= 1'b1;
                        data_ENC  <= data2send;
                        timer     <= TMR_LOAD;
                        state     <= WAIT_RX;
                    end
                end
                WAIT_RX: begin
                    if (timer != '0)
                        timer <= timer - TMR_W'(1);
                    // A reply on the expiry cycle wins over the timeout.
                    if (pkt) begin
                        read_DEC <= 1'b1;
                        if (error_DEC) begin
                            err_code <= ERR_DECODE;
                        end else if (data_DEC != data_expected) begin
                            err_code <= ERR_MISMATCH;
                        end else begin
                            expected_data_received <= 1'b1;
                            err_code               <= ERR_NONE;
                            gap_cnt                <= GAP_LOAD;
                            state                  <= SETTLE;
                        end
                    end else if (timer == '0) begin
                        err_code <= ERR_TIMEOUT;
                        if (timeout_count != '1)
                            timeout_count <= timeout_count + CNT_W'(1);
                        state <= SEND;
                    end
                end
                SETTLE: begin
                    if (gap_cnt == '0)
                        state <= SEND;
                    else
                        gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
